// File: rtl/exu_disp_oitf_if.sv
// ---------------------------------------------------------------------------
// exu_disp_oitf_if
// Bundles the dispatch, ALU and long-pipe retire signals of exu_disp_oitf.
//   master : decode/ALU/writeback side (drives disp_i_*, alu ready, ret_ena)
//   slave  : the dispatch stage itself
// Signals:
//   disp_i_valid/ready      decode -> dispatch handshake
//   disp_i_rs1en/rs2en/rdwen, disp_i_rs1idx/rs2idx/rdidx, disp_i_pc, disp_i_longp
//   disp_o_alu_valid/ready  dispatch -> ALU handshake, disp_o_alu_itag entry tag
//   ret_ena                 long-pipe writeback retires the oldest entry
//   ret_rdwen/rdidx/pc/itag contents of the oldest entry
// ---------------------------------------------------------------------------
interface exu_disp_oitf_if #(
  parameter int OITF_DEPTH = 4,
  parameter int RFIDX_W    = 5,
  parameter int PC_W       = 32,
  localparam int ITAG_W    = $clog2(OITF_DEPTH)
);
  logic               disp_i_valid;
  logic               disp_i_ready;
  logic               disp_i_rs1en;
  logic               disp_i_rs2en;
  logic               disp_i_rdwen;
  logic [RFIDX_W-1:0] disp_i_rs1idx;
  logic [RFIDX_W-1:0] disp_i_rs2idx;
  logic [RFIDX_W-1:0] disp_i_rdidx;
  logic [PC_W-1:0]    disp_i_pc;
  logic               disp_i_longp;
  logic               disp_o_alu_valid;
  logic               disp_o_alu_ready;
  logic [ITAG_W-1:0]  disp_o_alu_itag;
  logic               ret_ena;
  logic               ret_rdwen;
  logic [RFIDX_W-1:0] ret_rdidx;
  logic [PC_W-1:0]    ret_pc;
  logic [ITAG_W-1:0]  ret_itag;

  modport master (
    output disp_i_valid, disp_i_rs1en, disp_i_rs2en, disp_i_rdwen,
           disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx, disp_i_pc, disp_i_longp,
           disp_o_alu_ready, ret_ena,
    input  disp_i_ready, disp_o_alu_valid, disp_o_alu_itag,
           ret_rdwen, ret_rdidx, ret_pc, ret_itag
  );

  modport slave (
    input  disp_i_valid, disp_i_rs1en, disp_i_rs2en, disp_i_rdwen,
           disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx, disp_i_pc, disp_i_longp,
           disp_o_alu_ready, ret_ena,
    output disp_i_ready, disp_o_alu_valid, disp_o_alu_itag,
           ret_rdwen, ret_rdidx, ret_pc, ret_itag
  );
endinterface

// File: rtl/exu_disp_oitf.sv
// ---------------------------------------------------------------------------
// exu_disp_oitf
// Dispatch stage with an integrated Outstanding Instruction Track FIFO.
// Every instruction goes straight (combinationally) to the ALU; long-pipe ops
// additionally take an in-order OITF entry that lives until long-pipe
// writeback retires it. Dispatch stalls on RAW/WAW hazards against any live
// entry, on flush, and when a long-pipe op meets a full OITF.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   bus (slave)         dispatch / ALU / retire signals (exu_disp_oitf_if)
//   flush               synchronous kill of all outstanding entries
//   oitf_empty/full     occupancy flags
//   oitf_cnt            number of live entries (ITAG_W+1 bits)
// ---------------------------------------------------------------------------
module exu_disp_oitf #(
  parameter int OITF_DEPTH = 4,
  parameter int RFIDX_W    = 5,
  parameter int PC_W       = 32,
  localparam int ITAG_W    = $clog2(OITF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  exu_disp_oitf_if.slave    bus,
  input  logic              flush,
  output logic              oitf_empty,
  output logic              oitf_full,
  output logic [ITAG_W:0]   oitf_cnt
);

  localparam logic [ITAG_W:0] PTR_ONE = {{ITAG_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ITAG_W:0]     wptr_q, wptr_d;
  logic [ITAG_W:0]     rptr_q, rptr_d;
  logic [OITF_DEPTH-1:0] vld_q, vld_d;
  logic [OITF_DEPTH-1:0] rdwen_q, rdwen_d;
  logic [RFIDX_W-1:0]  rdidx_q [OITF_DEPTH];
  logic [RFIDX_W-1:0]  rdidx_d [OITF_DEPTH];
  logic [PC_W-1:0]     pc_q    [OITF_DEPTH];
  logic [PC_W-1:0]     pc_d    [OITF_DEPTH];

  logic [ITAG_W-1:0]   widx;
  logic [ITAG_W-1:0]   ridx;
  logic                raw;
  logic                waw;
  logic                cond;
  logic                alloc;
  logic                retire;

  assign widx       = wptr_q[ITAG_W-1:0];
  assign ridx       = rptr_q[ITAG_W-1:0];
  assign oitf_empty = (wptr_q == rptr_q);
  assign oitf_full  = (widx == ridx) && (wptr_q[ITAG_W] != rptr_q[ITAG_W]);
  assign oitf_cnt   = wptr_q - rptr_q;

  // Hazard scan over every live entry that writes a register. x0 is never a
  // dependency, so a zero index on either side cannot match.
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (vld_q[i] && rdwen_q[i]) begin
        if (bus.disp_i_rs1en && (bus.disp_i_rs1idx != '0) &&
            (rdidx_q[i] == bus.disp_i_rs1idx))
          raw = 1'b1;
        if (bus.disp_i_rs2en && (bus.disp_i_rs2idx != '0) &&
            (rdidx_q[i] == bus.disp_i_rs2idx))
          raw = 1'b1;
        if (bus.disp_i_rdwen && (bus.disp_i_rdidx != '0) &&
            (rdidx_q[i] == bus.disp_i_rdidx))
          waw = 1'b1;
      end
    end
  end

  // Full is taken from the current state only: a retire in the same cycle
  // does not open a slot for a long-pipe op until the next cycle.
  assign cond = ~raw & ~waw & ~flush & (bus.disp_i_longp ? ~oitf_full : 1'b1);

  assign bus.disp_o_alu_valid = bus.disp_i_valid & cond;
  assign bus.disp_i_ready     = cond & bus.disp_o_alu_ready;
  assign bus.disp_o_alu_itag  = widx;

  assign alloc  = bus.disp_o_alu_valid & bus.disp_o_alu_ready & bus.disp_i_longp;
  assign retire = bus.ret_ena & ~oitf_empty;

  assign bus.ret_rdwen = rdwen_q[ridx];
  assign bus.ret_rdidx = rdidx_q[ridx];
  assign bus.ret_pc    = pc_q[ridx];
  assign bus.ret_itag  = ridx;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    vld_d   = vld_q;
    rdwen_d = rdwen_q;
    rdidx_d = rdidx_q;
    pc_d    = pc_q;
    if (flush) begin
      // Flush wins over any alloc or retire in the same cycle.
      wptr_d = '0;
      rptr_d = '0;
      vld_d  = '0;
    end else begin
      if (alloc) begin
        vld_d[widx]   = 1'b1;
        rdwen_d[widx] = bus.disp_i_rdwen;
        rdidx_d[widx] = bus.disp_i_rdidx;
        pc_d[widx]    = bus.disp_i_pc;
        wptr_d        = wptr_q + PTR_ONE;
      end
      // Alloc and retire never target the same slot: that would need the
      // FIFO to be both full (alloc blocked) and non-empty at one index.
      if (retire) begin
        vld_d[ridx] = 1'b0;
        rptr_d      = rptr_q + PTR_ONE;
      end
    end
  end

  // State register: entry payload is reset too so the retire port shows a
  // clean entry 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      vld_q   <= '0;
      rdwen_q <= '0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
        rdidx_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      vld_q   <= vld_d;
      rdwen_q <= rdwen_d;
      rdidx_q <= rdidx_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_exu_disp_oitf.sv
// ---------------------------------------------------------------------------
// tb_exu_disp_oitf
// Table-driven bench for exu_disp_oitf (DEPTH=4) with a scoreboard of
// allocated entries that is checked against the retire port.
// ---------------------------------------------------------------------------
module tb_exu_disp_oitf;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       oitf_empty;
  logic       oitf_full;
  logic [2:0] oitf_cnt;

  exu_disp_oitf_if #(.OITF_DEPTH(4), .RFIDX_W(5), .PC_W(32)) bus ();

  exu_disp_oitf #(.OITF_DEPTH(4), .RFIDX_W(5), .PC_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .oitf_empty (oitf_empty),
    .oitf_full  (oitf_full),
    .oitf_cnt   (oitf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {valid, longp, rs1en, rs2en, rdwen}; sd = {ret_ena, flush, alu_ready}
  // ex = {expected alu_valid, expected disp_i_ready}; ecnt = count after the edge
  typedef struct {
    logic [4:0] ctl;
    logic [2:0] sd;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] rd;
    logic [1:0] ex;
    logic [1:0] etag;
    logic [2:0] ecnt;
  } vec_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [1:0]  tag;
  } ent_t;

  ent_t sb[$];
  vec_t tbl[23];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [4:0] ctl, input logic [2:0] sd,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] rd, input logic [1:0] ex,
                              input logic [1:0] etag, input logic [2:0] ecnt);
    vec_t v;
    v.ctl = ctl; v.sd = sd; v.r1 = r1; v.r2 = r2; v.rd = rd;
    v.ex = ex; v.etag = etag; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t t, input logic [31:0] pc);
    ent_t e;
    @(negedge clk);
    {bus.disp_i_valid, bus.disp_i_longp, bus.disp_i_rs1en, bus.disp_i_rs2en,
     bus.disp_i_rdwen} = t.ctl;
    {bus.ret_ena, flush, bus.disp_o_alu_ready} = t.sd;
    bus.disp_i_rs1idx = t.r1;
    bus.disp_i_rs2idx = t.r2;
    bus.disp_i_rdidx  = t.rd;
    bus.disp_i_pc     = pc;
    #1;
    chk("alu_valid", 64'(bus.disp_o_alu_valid), 64'(t.ex[1]));
    chk("disp_ready", 64'(bus.disp_i_ready), 64'(t.ex[0]));
    if (t.ex[1] && t.ctl[3]) chk("alu_itag", 64'(bus.disp_o_alu_itag), 64'(t.etag));
    if (t.sd[2] && !t.sd[1] && sb.size() > 0) begin
      e = sb.pop_front();
      chk("ret_rdwen", 64'(bus.ret_rdwen), 64'(e.wen));
      chk("ret_rdidx", 64'(bus.ret_rdidx), 64'(e.rd));
      chk("ret_pc",    64'(bus.ret_pc),    64'(e.pc));
      chk("ret_itag",  64'(bus.ret_itag),  64'(e.tag));
    end
    if (t.ex[1] && t.sd[0] && t.ctl[3]) begin
      e.wen = t.ctl[0]; e.rd = t.rd; e.pc = pc; e.tag = t.etag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (t.sd[1]) sb.delete();
    chk("oitf_cnt",   64'(oitf_cnt),   64'(t.ecnt));
    chk("oitf_empty", 64'(oitf_empty), 64'(t.ecnt == 3'd0));
    chk("oitf_full",  64'(oitf_full),  64'(t.ecnt == 3'd4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Fill/drain, full-blocking with retire, RAW/WAW stalls, x0, wrap, empty retire.
    tbl[0]  = mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd1, 2'b11, 2'd0, 3'd1);
    tbl[1]  = mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd2, 2'b11, 2'd1, 3'd2);
    tbl[2]  = mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd3, 2'b11, 2'd2, 3'd3);
    tbl[3]  = mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd4, 2'b11, 2'd3, 3'd4);
    tbl[4]  = mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd6, 2'b00, 2'd0, 3'd4);
    tbl[5]  = mk(5'b11001, 3'b101, 5'd0, 5'd0, 5'd6, 2'b00, 2'd0, 3'd3);
    tbl[6]  = mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd6, 2'b11, 2'd0, 3'd4);
    tbl[7]  = mk(5'b10101, 3'b001, 5'd2, 5'd0, 5'd7, 2'b00, 2'd0, 3'd4);
    tbl[8]  = mk(5'b10101, 3'b101, 5'd2, 5'd0, 5'd7, 2'b00, 2'd0, 3'd3);
    tbl[9]  = mk(5'b10101, 3'b001, 5'd2, 5'd0, 5'd7, 2'b11, 2'd0, 3'd3);
    tbl[10] = mk(5'b10010, 3'b001, 5'd0, 5'd3, 5'd0, 2'b00, 2'd0, 3'd3);
    tbl[11] = mk(5'b10001, 3'b001, 5'd0, 5'd0, 5'd4, 2'b00, 2'd0, 3'd3);
    tbl[12] = mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd0, 2'b11, 2'd1, 3'd4);
    tbl[13] = mk(5'b10101, 3'b001, 5'd0, 5'd0, 5'd0, 2'b11, 2'd0, 3'd4);
    tbl[14] = mk(5'b10000, 3'b000, 5'd0, 5'd0, 5'd0, 2'b10, 2'd0, 3'd4);
    tbl[15] = mk(5'b00000, 3'b101, 5'd0, 5'd0, 5'd0, 2'b01, 2'd0, 3'd3);
    tbl[16] = mk(5'b00000, 3'b101, 5'd0, 5'd0, 5'd0, 2'b01, 2'd0, 3'd2);
    tbl[17] = mk(5'b11001, 3'b101, 5'd0, 5'd0, 5'd8, 2'b11, 2'd2, 3'd2);
    tbl[18] = mk(5'b00000, 3'b101, 5'd0, 5'd0, 5'd0, 2'b01, 2'd0, 3'd1);
    tbl[19] = mk(5'b00000, 3'b101, 5'd0, 5'd0, 5'd0, 2'b01, 2'd0, 3'd0);
    tbl[20] = mk(5'b00000, 3'b101, 5'd0, 5'd0, 5'd0, 2'b01, 2'd0, 3'd0);
    tbl[21] = mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd9, 2'b11, 2'd3, 3'd1);
    tbl[22] = mk(5'b00000, 3'b101, 5'd0, 5'd0, 5'd0, 2'b01, 2'd0, 3'd0);

    rst = 1'b1;
    flush = 1'b0;
    bus.disp_i_valid = 1'b0; bus.disp_i_longp = 1'b0;
    bus.disp_i_rs1en = 1'b0; bus.disp_i_rs2en = 1'b0; bus.disp_i_rdwen = 1'b0;
    bus.disp_i_rs1idx = '0; bus.disp_i_rs2idx = '0; bus.disp_i_rdidx = '0;
    bus.disp_i_pc = '0; bus.disp_o_alu_ready = 1'b1; bus.ret_ena = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_empty", 64'(oitf_empty), 64'd1);
    chk("rst_full", 64'(oitf_full), 64'd0);
    chk("rst_cnt", 64'(oitf_cnt), 64'd0);
    chk("rst_ret_rdwen", 64'(bus.ret_rdwen), 64'd0);
    chk("rst_ret_rdidx", 64'(bus.ret_rdidx), 64'd0);
    chk("rst_ret_pc", 64'(bus.ret_pc), 64'd0);
    chk("rst_alu_valid", 64'(bus.disp_o_alu_valid), 64'd0);
    chk("rst_ready", 64'(bus.disp_i_ready), 64'd1);

    for (int i = 0; i < 23; i++) apply(tbl[i], 32'h100 + 32'(i) * 32'd4);

    // Flush with a long-pipe op pending after three allocations.
    apply(mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd10, 2'b11, 2'd0, 3'd1), 32'h200);
    apply(mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd11, 2'b11, 2'd1, 3'd2), 32'h204);
    apply(mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd12, 2'b11, 2'd2, 3'd3), 32'h208);
    apply(mk(5'b11001, 3'b011, 5'd0, 5'd0, 5'd13, 2'b00, 2'd0, 3'd0), 32'h20c);
    apply(mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd14, 2'b11, 2'd0, 3'd1), 32'h210);
    apply(mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd15, 2'b11, 2'd1, 3'd2), 32'h214);

    // Asynchronous reset while an allocation is in flight.
    @(negedge clk);
    bus.disp_i_valid = 1'b1; bus.disp_i_longp = 1'b1; bus.disp_i_rdwen = 1'b1;
    bus.disp_i_rdidx = 5'd16; bus.disp_i_pc = 32'h218; bus.ret_ena = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", 64'(oitf_empty), 64'd1);
    chk("arst_cnt", 64'(oitf_cnt), 64'd0);
    chk("arst_full", 64'(oitf_full), 64'd0);
    chk("arst_ret_rdidx", 64'(bus.ret_rdidx), 64'd0);
    chk("arst_ret_pc", 64'(bus.ret_pc), 64'd0);
    @(posedge clk);
    #1;
    chk("arst_cnt_edge", 64'(oitf_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.disp_i_valid = 1'b0;
    sb.delete();
    apply(mk(5'b11001, 3'b001, 5'd0, 5'd0, 5'd17, 2'b11, 2'd0, 3'd1), 32'h21c);
    apply(mk(5'b00000, 3'b101, 5'd0, 5'd0, 5'd0, 2'b01, 2'd0, 3'd0), 32'h220);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
